// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CR16-style datapath: owns the IR and the
// FETCH/DECODE/EXEC/MEM sequencer and drives the PC, memories, register file and ALU.
module cpu_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  output logic        pc_en,
  output logic [15:0] pc_next,
  input  logic [15:0] imem_dout,
  output logic        imem_en,
  output logic [8:0]  imem_addr,
  output logic        dmem_en,
  output logic        dmem_we,
  output logic [8:0]  dmem_addr,
  output logic [15:0] dmem_din,
  input  logic [15:0] dmem_dout,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  input  logic [15:0] rf_ra_data,
  input  logic [15:0] rf_rb_data,
  output logic [4:0]  alu_op,
  output logic [4:0]  alu_shamt,
  output logic        alu_flags_en,
  output logic [4:0]  alu_flags_sel,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [15:0] ir_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEMJ  = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUBC = 4'b1010;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [3:0]  op, rd, ext;
  logic        rt_valid;
  logic [4:0]  rt_mask;
  logic        is_rtype, is_shift, is_load, is_stor, is_jal, is_jcond, is_bcond;
  logic        taken;
  logic [15:0] pc_plus1, pc_branch;

  // PSR order is {C,N,Z,F,L}.
  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
    logic c, n, z, fl, l;
    {c, n, z, fl, l} = f;
    case (cc)
      4'b0000: cond_met = z;
      4'b0001: cond_met = !z;
      4'b0010: cond_met = c;
      4'b0011: cond_met = !c;
      4'b0100: cond_met = l;
      4'b0101: cond_met = !l;
      4'b0110: cond_met = n;
      4'b0111: cond_met = !n;
      4'b1000: cond_met = fl;
      4'b1001: cond_met = !fl;
      4'b1010: cond_met = !l && !z;
      4'b1011: cond_met = l || z;
      4'b1100: cond_met = !n && !z;
      4'b1101: cond_met = n || z;
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign ext = ir_q[7:4];

  assign pc_plus1  = pc_in + 16'd1;
  assign pc_branch = pc_in + {{8{ir_q[7]}}, ir_q[7:0]};
  assign taken     = cond_met(rd, alu_flags);

  // NOTE: every combinational output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    rt_valid = 1'b1;
    rt_mask  = 5'b00000;
    case (ext)
      4'b0001, 4'b0010, 4'b0011:          rt_mask = 5'b01100;
      4'b0101, 4'b0111, 4'b1001, 4'b1010: rt_mask = 5'b11111;
      4'b0110:                            rt_mask = 5'b10000;
      4'b1011:                            rt_mask = 5'b01101;
      4'b1101:                            rt_mask = 5'b00000;
      default:                            rt_valid = 1'b0;
    endcase
  end

  assign is_rtype = (op == OP_RTYPE) && rt_valid;
  assign is_shift = (op == OP_SHIFT) && (ir_q[7:5] == 3'b000);
  assign is_load  = (op == OP_MEMJ) && (ext == 4'b0000);
  assign is_stor  = (op == OP_MEMJ) && (ext == 4'b0100);
  assign is_jal   = (op == OP_MEMJ) && (ext == 4'b1000);
  assign is_jcond = (op == OP_MEMJ) && (ext == 4'b1100);
  assign is_bcond = (op == OP_BCOND);

  assign rf_waddr   = rd;
  assign rf_ra_addr = rd;
  assign rf_rb_addr = ir_q[3:0];
  assign ir_out     = ir_q;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    pc_en         = 1'b0;
    pc_next       = pc_plus1;
    imem_en       = 1'b0;
    imem_addr     = 9'd0;
    dmem_en       = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = 9'd0;
    dmem_din      = 16'd0;
    rf_we         = 1'b0;
    rf_wdata      = 16'd0;
    alu_op        = 5'd0;
    alu_shamt     = 5'd0;
    alu_flags_en  = 1'b0;
    alu_flags_sel = 5'd0;
    alu_cin       = 1'b0;

    // While reset is held the state already reads FETCH, but nothing may be enabled yet.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_en   = 1'b1;
          imem_addr = pc_in[8:0];
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          ir_d    = imem_dout;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (is_load) begin
            dmem_en   = 1'b1;
            dmem_addr = rf_rb_data[8:0];
            state_d   = S_MEM;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
            if (is_rtype) begin
              alu_op        = {1'b0, ext};
              rf_wdata      = alu_out;
              rf_we         = (ext != EXT_CMP);
              alu_flags_sel = rt_mask;
              alu_flags_en  = |rt_mask;
              alu_cin       = ((ext == EXT_ADDC) || (ext == EXT_SUBC)) ? alu_flags[4] : 1'b0;
            end else if (is_shift) begin
              alu_op    = 5'b10000;
              alu_shamt = ir_q[4:0];
              rf_we     = 1'b1;
              rf_wdata  = alu_out;
            end else if (is_stor) begin
              dmem_en   = 1'b1;
              dmem_we   = 1'b1;
              dmem_addr = rf_rb_data[8:0];
              dmem_din  = rf_ra_data;
            end else if (is_jal) begin
              rf_we    = 1'b1;
              rf_wdata = pc_plus1;
              pc_next  = rf_rb_data;
            end else if (is_jcond) begin
              pc_next = taken ? rf_rb_data : pc_plus1;
            end else if (is_bcond) begin
              pc_next = taken ? pc_branch : pc_plus1;
            end
          end
        end
        S_MEM: begin
          rf_we    = 1'b1;
          rf_wdata = dmem_dout;
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed cases plus randomized instructions
// compared cycle by cycle against an instruction-level model of the control rules.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in, imem_dout, dmem_dout, rf_ra_data, rf_rb_data, alu_out;
  logic [4:0]  alu_flags;
  logic        pc_en, imem_en, dmem_en, dmem_we, rf_we, alu_flags_en, alu_cin;
  logic [15:0] pc_next, dmem_din, rf_wdata, ir_out;
  logic [8:0]  imem_addr, dmem_addr;
  logic [3:0]  rf_waddr, rf_ra_addr, rf_rb_addr;
  logic [4:0]  alu_op, alu_shamt, alu_flags_sel;

  cpu_control_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .pc_in(pc_in), .pc_en(pc_en), .pc_next(pc_next),
    .imem_dout(imem_dout), .imem_en(imem_en), .imem_addr(imem_addr),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_flags_en(alu_flags_en),
    .alu_flags_sel(alu_flags_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_flags(alu_flags), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  localparam int PH_FETCH = 0;
  localparam int PH_QUIET = 1;  // DECODE, or reset held
  localparam int PH_EXEC  = 2;
  localparam int PH_MEM   = 3;

  typedef struct {
    logic        pc_en;
    logic [15:0] pc_next;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic        dmem_en;
    logic        dmem_we;
    logic [8:0]  dmem_addr;
    logic [15:0] dmem_din;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [4:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic        alu_flags_en;
    logic [4:0]  alu_flags_sel;
    logic        alu_cin;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cur_ir   = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Conditions come in complementary pairs: cc[3:1] selects the base test, cc[0] inverts it.
  function automatic logic cond_ref(input logic [3:0] cc, input logic [4:0] f);
    logic c, n, z, fl, l;
    logic [7:0] base;
    {c, n, z, fl, l} = f;
    base = {1'b1, !n && !z, !l && !z, fl, n, l, c, z};
    return base[cc[3:1]] ^ cc[0];
  endfunction

  function automatic exp_t model(input int ph, input logic [15:0] ir, input logic [15:0] pc,
                                 input logic [15:0] ra, input logic [15:0] rb,
                                 input logic [15:0] aout, input logic [15:0] dout,
                                 input logic [4:0] fl);
    exp_t e;
    logic [3:0] op, ext;
    logic [4:0] mask;
    logic       valid;
    e = '{pc_en: 1'b0, pc_next: pc + 16'd1, imem_en: 1'b0, imem_addr: 9'd0,
          dmem_en: 1'b0, dmem_we: 1'b0, dmem_addr: 9'd0, dmem_din: 16'd0,
          rf_we: 1'b0, rf_wdata: 16'd0, alu_op: 5'd0, alu_shamt: 5'd0,
          alu_flags_en: 1'b0, alu_flags_sel: 5'd0, alu_cin: 1'b0};
    op  = ir[15:12];
    ext = ir[7:4];
    if (ph == PH_FETCH) begin
      e.imem_en   = 1'b1;
      e.imem_addr = pc[8:0];
    end else if (ph == PH_MEM) begin
      e.rf_we    = 1'b1;
      e.rf_wdata = dout;
      e.pc_en    = 1'b1;
    end else if (ph == PH_EXEC) begin
      if (op == 4'h4 && ext == 4'h0) begin
        e.dmem_en   = 1'b1;
        e.dmem_addr = rb[8:0];
      end else begin
        e.pc_en = 1'b1;
        if (op == 4'h0) begin
          valid = 1'b1;
          case (ext)
            4'h1, 4'h2, 4'h3:       mask = 5'b01100;  // AND OR XOR
            4'h5, 4'h7, 4'h9, 4'hA: mask = 5'b11111;  // ADD ADDC SUB SUBC
            4'h6:                   mask = 5'b10000;  // ADDU
            4'hB:                   mask = 5'b01101;  // CMP
            4'hD:                   mask = 5'b00000;  // MOV
            default: begin mask = 5'b00000; valid = 1'b0; end
          endcase
          if (valid) begin
            e.alu_op        = {1'b0, ext};
            e.rf_wdata      = aout;
            e.rf_we         = (ext != 4'hB);
            e.alu_flags_sel = mask;
            e.alu_flags_en  = (mask != 5'b0);
            e.alu_cin       = (ext == 4'h7 || ext == 4'hA) ? fl[4] : 1'b0;
          end
        end else if (op == 4'h8 && ir[7:5] == 3'b000) begin
          e.alu_op    = 5'b10000;
          e.alu_shamt = ir[4:0];
          e.rf_we     = 1'b1;
          e.rf_wdata  = aout;
        end else if (op == 4'h4 && ext == 4'h4) begin
          e.dmem_en   = 1'b1;
          e.dmem_we   = 1'b1;
          e.dmem_addr = rb[8:0];
          e.dmem_din  = ra;
        end else if (op == 4'h4 && ext == 4'h8) begin
          e.rf_we    = 1'b1;
          e.rf_wdata = pc + 16'd1;
          e.pc_next  = rb;
        end else if (op == 4'h4 && ext == 4'hC) begin
          if (cond_ref(ir[11:8], fl)) e.pc_next = rb;
        end else if (op == 4'hC) begin
          if (cond_ref(ir[11:8], fl)) e.pc_next = pc + {{8{ir[7]}}, ir[7:0]};
        end
      end
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".pc_en"},         32'(pc_en),         32'(e.pc_en));
    check({tag, ".pc_next"},       32'(pc_next),       32'(e.pc_next));
    check({tag, ".imem_en"},       32'(imem_en),       32'(e.imem_en));
    check({tag, ".imem_addr"},     32'(imem_addr),     32'(e.imem_addr));
    check({tag, ".dmem_en"},       32'(dmem_en),       32'(e.dmem_en));
    check({tag, ".dmem_we"},       32'(dmem_we),       32'(e.dmem_we));
    check({tag, ".dmem_addr"},     32'(dmem_addr),     32'(e.dmem_addr));
    check({tag, ".dmem_din"},      32'(dmem_din),      32'(e.dmem_din));
    check({tag, ".rf_we"},         32'(rf_we),         32'(e.rf_we));
    check({tag, ".rf_wdata"},      32'(rf_wdata),      32'(e.rf_wdata));
    check({tag, ".alu_op"},        32'(alu_op),        32'(e.alu_op));
    check({tag, ".alu_shamt"},     32'(alu_shamt),     32'(e.alu_shamt));
    check({tag, ".alu_flags_en"},  32'(alu_flags_en),  32'(e.alu_flags_en));
    check({tag, ".alu_flags_sel"}, 32'(alu_flags_sel), 32'(e.alu_flags_sel));
    check({tag, ".alu_cin"},       32'(alu_cin),       32'(e.alu_cin));
    check({tag, ".ir_out"},        32'(ir_out),        32'(cur_ir));
    check({tag, ".rf_waddr"},      32'(rf_waddr),      32'(cur_ir[11:8]));
    check({tag, ".rf_ra_addr"},    32'(rf_ra_addr),    32'(cur_ir[11:8]));
    check({tag, ".rf_rb_addr"},    32'(rf_rb_addr),    32'(cur_ir[3:0]));
  endtask

  // Entered 1 time unit after the edge that starts FETCH; returns at the same point of the next FETCH.
  task automatic run_instr(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                           input logic [15:0] ra, input logic [15:0] rb,
                           input logic [15:0] aout, input logic [15:0] dout,
                           input logic [4:0] fl, input bit abort_in_exec);
    pc_in = pc; rf_ra_data = ra; rf_rb_data = rb; alu_out = aout;
    dmem_dout = dout; alu_flags = fl;
    imem_dout = ~ir;  // stale word: IR must not capture during FETCH
    #1 compare({tag, ".fetch"}, model(PH_FETCH, cur_ir, pc, ra, rb, aout, dout, fl));
    @(posedge clk); #1;
    imem_dout = ir;
    #1 compare({tag, ".decode"}, model(PH_QUIET, cur_ir, pc, ra, rb, aout, dout, fl));
    @(posedge clk); #1;
    cur_ir    = ir;
    imem_dout = 16'hDEAD;
    #1 compare({tag, ".exec"}, model(PH_EXEC, ir, pc, ra, rb, aout, dout, fl));
    if (abort_in_exec) begin
      rst_n  = 1'b0;
      cur_ir = 16'd0;
      #1 compare({tag, ".rst_async"}, model(PH_QUIET, 16'd0, pc, ra, rb, aout, dout, fl));
      @(posedge clk); #1;
      compare({tag, ".rst_held"}, model(PH_QUIET, 16'd0, pc, ra, rb, aout, dout, fl));
      rst_n = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (ir[15:12] == 4'h4 && ir[7:4] == 4'h0) begin
      #1 compare({tag, ".mem"}, model(PH_MEM, ir, pc, ra, rb, aout, dout, fl));
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] rd, ext, rs;
    logic [15:0] r;
    rd  = 4'($urandom);
    ext = 4'($urandom);
    rs  = 4'($urandom);
    r   = 16'($urandom);
    case ($urandom_range(0, 7))
      0: return {4'h0, rd, ext, rs};
      1: return {4'h8, rd, ($urandom_range(0, 1) != 0) ? 3'b000 : 3'($urandom), r[4:0]};
      2: return {4'h4, rd, 4'h0, rs};
      3: return {4'h4, rd, 4'h4, rs};
      4: return {4'h4, rd, 4'h8, rs};
      5: return {4'h4, rd, 4'hC, rs};
      6: return {4'hC, rd, r[7:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    pc_in = 16'h0042; imem_dout = 16'h1234; dmem_dout = 16'h0;
    rf_ra_data = 16'h0; rf_rb_data = 16'h0; alu_out = 16'h0; alu_flags = 5'b0;
    #2 compare("reset", model(PH_QUIET, 16'd0, 16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 5'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr("add",   16'h0152, 16'h0020, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 0);
    run_instr("load",  16'h4203, 16'h0021, 16'h0000, 16'h0001, 16'h0000, 16'h00FF, 5'b00000, 0);
    run_instr("stor",  16'h4243, 16'h0022, 16'h00AA, 16'h0001, 16'h0000, 16'h0000, 5'b00000, 0);
    run_instr("jal",   16'h4280, 16'h0005, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 5'b00000, 0);
    run_instr("beq_t", 16'hC004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00100, 0);
    run_instr("beq_n", 16'hC004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0);
    run_instr("buc",   16'hCEFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0);
    run_instr("bnev",  16'hCF10, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b11111, 0);
    run_instr("addc",  16'h0371, 16'h0030, 16'h0001, 16'h0002, 16'h0004, 16'h0000, 5'b10000, 0);
    run_instr("cmp",   16'h04B5, 16'h0031, 16'h0009, 16'h0009, 16'h0000, 16'h0000, 5'b00000, 0);
    run_instr("shr",   16'h861F, 16'h0032, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 5'b00000, 0);
    run_instr("rst",   16'h0152, 16'h0040, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 1);
    run_instr("after", 16'h0D13, 16'h0041, 16'h0005, 16'h0006, 16'h00C3, 16'h0000, 5'b00000, 0);

    for (int i = 0; i < 300; i++) begin
      run_instr($sformatf("rnd%0d", i), rand_instr(), 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
